// File: rtl/cg_enable_scheduler.sv
// cg_enable_scheduler
// Clock-gate enable scheduler for a shared datapath register. Wakes the gated
// clock when any requester asks, arbitrates requesters round-robin while
// active, and gates the clock off again after a run of idle cycles.
module cg_enable_scheduler #(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int IDLE_CYC = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic               clk_gt,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic               cg_en,
    output logic [DW-1:0]      dp_din,
    output logic               dp_valid,
    output logic [1:0]         state,
    output logic [15:0]        sleep_cnt
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        WAKE      = 2'd1,
        ACTIVE    = 2'd2,
        IDLE_WAIT = 2'd3
    } st_e;

    st_e           st;
    logic [PW-1:0] rr_ptr;
    logic [3:0]    wake_cnt;
    logic [7:0]    idle_cnt;

    logic          any_req;
    logic          found;
    logic [PW:0]   cand;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] rr_next;
    logic [DW-1:0] gnt_word;

    // Saturating increment for the sleep event counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign state   = st;
    assign any_req = |req;

    // Round-robin arbiter: scan requesters starting at rr_ptr, grant the first
    // one found; grants are only issued while the datapath clock is active.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (st == ACTIVE) begin
            for (int i = 0; i < NREQ; i++) begin
                cand = {1'b0, rr_ptr} + (PW+1)'(i);
                if (cand >= (PW+1)'(NREQ)) begin
                    cand = cand - (PW+1)'(NREQ);
                end
                if (!found && req[cand[PW-1:0]]) begin
                    found                = 1'b1;
                    gnt[cand[PW-1:0]]    = 1'b1;
                    gnt_idx              = cand[PW-1:0];
                end
            end
        end
    end

    // Data word of the granted requester and the pointer position after it.
    always_comb begin
        gnt_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_word = din[k*DW +: DW];
            end
        end
        rr_next = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
    end

    // Power-state FSM with registered enable, datapath word and valid strobe.
    // cg_en is written alongside every state change so it tracks the next state.
    always_ff @(posedge clk_gt or negedge rst_n) begin
        if (!rst_n) begin
            st        <= OFF;
            cg_en     <= 1'b0;
            dp_din    <= '0;
            dp_valid  <= 1'b0;
            rr_ptr    <= '0;
            wake_cnt  <= '0;
            idle_cnt  <= '0;
            sleep_cnt <= '0;
        end else begin
            dp_valid <= 1'b0;
            case (st)
                OFF: begin
                    if (any_req) begin
                        st       <= WAKE;
                        cg_en    <= 1'b1;
                        wake_cnt <= 4'(WAKE_CYC - 1);
                    end
                end
                WAKE: begin
                    if (wake_cnt == 4'd0) begin
                        st <= ACTIVE;
                    end else begin
                        wake_cnt <= wake_cnt - 4'd1;
                    end
                end
                ACTIVE: begin
                    if (found) begin
                        dp_din   <= gnt_word;
                        dp_valid <= 1'b1;
                        rr_ptr   <= rr_next;
                    end else begin
                        st       <= IDLE_WAIT;
                        idle_cnt <= 8'(IDLE_CYC - 1);
                    end
                end
                IDLE_WAIT: begin
                    // A request arriving on the final idle cycle keeps the clock on.
                    if (any_req) begin
                        st <= ACTIVE;
                    end else if (idle_cnt == 8'd0) begin
                        st        <= OFF;
                        cg_en     <= 1'b0;
                        sleep_cnt <= sat_inc16(sleep_cnt);
                    end else begin
                        idle_cnt <= idle_cnt - 8'd1;
                    end
                end
                default: begin
                    st    <= OFF;
                    cg_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cg_enable_scheduler.sv
// Directed testbench for cg_enable_scheduler: wake path, round-robin order,
// gate-off timing, idle/request race, mid-operation reset, dropped request.
module tb_cg_enable_scheduler;

    logic        clk_gt = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic        cg_en;
    logic [3:0]  dp_din;
    logic        dp_valid;
    logic [1:0]  state;
    logic [15:0] sleep_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    cg_enable_scheduler #(
        .NREQ(4), .DW(4), .IDLE_CYC(8), .WAKE_CYC(2)
    ) dut (
        .clk_gt    (clk_gt),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .cg_en     (cg_en),
        .dp_din    (dp_din),
        .dp_valid  (dp_valid),
        .state     (state),
        .sleep_cnt (sleep_cnt)
    );

    always #5 clk_gt = ~clk_gt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and let registered outputs settle.
    task automatic step();
        @(posedge clk_gt);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"},    32'(state),     32'd0);
        chk({tag, ".cg_en"},    32'(cg_en),     32'd0);
        chk({tag, ".gnt"},      32'(gnt),       32'd0);
        chk({tag, ".dp_valid"}, 32'(dp_valid),  32'd0);
        chk({tag, ".dp_din"},   32'(dp_din),    32'd0);
    endtask

    int         order [5]  = '{0, 1, 2, 3, 0};
    logic [3:0] nib   [4]  = '{4'hA, 4'hB, 4'hC, 4'hD};

    initial begin
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        do_reset();

        // Reset state
        chk_all_zero("rst");
        chk("rst.sleep_cnt", 32'(sleep_cnt), 32'd0);

        // Wake path: single requester 0 with data A
        req = 4'b0001;
        din = 16'h000A;
        #1;
        chk("wake.off_gnt", 32'(gnt), 32'd0);
        step();
        chk("wake.state1", 32'(state), 32'd1);
        chk("wake.cg_en",  32'(cg_en), 32'd1);
        chk("wake.gnt1",   32'(gnt),   32'd0);
        step();
        chk("wake.state2", 32'(state), 32'd1);
        chk("wake.gnt2",   32'(gnt),   32'd0);
        step();
        chk("wake.active", 32'(state), 32'd2);
        chk("wake.gnt",    32'(gnt),   32'b0001);
        step();
        chk("wake.valid",  32'(dp_valid), 32'd1);
        chk("wake.din",    32'(dp_din),   32'hA);
        req = 4'b0000;
        #1;
        chk("idle.gnt0", 32'(gnt), 32'd0);

        // Gate-off: 8 IDLE_WAIT cycles with clock still enabled, then OFF
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("idle.state%0d", c), 32'(state), 32'd3);
            chk($sformatf("idle.cg_en%0d", c), 32'(cg_en), 32'd1);
        end
        chk("idle.valid0", 32'(dp_valid), 32'd0);
        chk("idle.din_hold", 32'(dp_din), 32'hA);
        step();
        chk("off.state", 32'(state),     32'd0);
        chk("off.cg_en", 32'(cg_en),     32'd0);
        chk("off.sleep", 32'(sleep_cnt), 32'd1);

        // Round-robin from rr_ptr=0 with all four requesting
        do_reset();
        req = 4'b1111;
        din = 16'hDCBA;
        step();
        step();
        step();
        chk("rr.active", 32'(state), 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr.gnt%0d", k), 32'(gnt), 32'(4'b0001 << order[k]));
            step();
            chk($sformatf("rr.valid%0d", k), 32'(dp_valid), 32'd1);
            chk($sformatf("rr.din%0d", k),   32'(dp_din),   32'(nib[order[k]]));
        end
        chk("rr.gnt_next", 32'(gnt), 32'b0010);

        // Race: request arrives exactly on the last idle cycle
        req = 4'b0000;
        #1;
        chk("race.gnt0", 32'(gnt), 32'd0);
        step();
        chk("race.idle",   32'(state),    32'd3);
        chk("race.valid0", 32'(dp_valid), 32'd0);
        for (int c = 0; c < 7; c++) begin
            step();
            chk($sformatf("race.cg_en%0d", c), 32'(cg_en), 32'd1);
        end
        req = 4'b0100;
        #1;
        chk("race.iw_gnt", 32'(gnt),   32'd0);
        chk("race.iw_st",  32'(state), 32'd3);
        step();
        chk("race.state", 32'(state),     32'd2);
        chk("race.cg_en", 32'(cg_en),     32'd1);
        chk("race.sleep", 32'(sleep_cnt), 32'd0);
        chk("race.gnt",   32'(gnt),       32'b0100);
        step();
        chk("race.valid", 32'(dp_valid), 32'd1);
        chk("race.din",   32'(dp_din),   32'hC);

        // Mid-operation reset with requesters 0 and 1 pending
        req = 4'b0011;
        #1;
        chk("mrst.pre_gnt", 32'(gnt), 32'b0001);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mrst");
        step();
        chk("mrst.valid_held", 32'(dp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mrst.wake", 32'(state), 32'd1);
        chk("mrst.cg_en", 32'(cg_en), 32'd1);
        step();
        step();
        #1;
        chk("mrst.gnt", 32'(gnt), 32'b0001);
        step();
        chk("mrst.valid", 32'(dp_valid), 32'd1);
        chk("mrst.din",   32'(dp_din),   32'hA);
        chk("mrst.gnt1",  32'(gnt),      32'b0010);

        // Requester 1 withdraws before being granted
        req = 4'b0001;
        #1;
        chk("drop.gnt", 32'(gnt), 32'b0001);
        step();
        chk("drop.din", 32'(dp_din), 32'hA);
        req = 4'b0000;
        #1;
        chk("drop.gnt0", 32'(gnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cg_enable_scheduler.md
CG_ENABLE_SCHEDULER -- requirements
Module: cg_enable_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the gated 4-bit datapath register; legal range 2..8.
REQ-002 Parameter DW, default 4: datapath width in bits.
REQ-003 Parameter IDLE_CYC, default 8: consecutive request-free cycles before the datapath clock is gated off; legal range 1..255.
REQ-004 Parameter WAKE_CYC, default 2: cycles of enable-high settling before the first grant after wake; legal range 1..15.
REQ-005 clk_gt  input  1  block clock, rising-edge; the clock fed to the gating cell, never gated by this block.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NREQ  per-requester transfer request; held high until granted.
REQ-008 din  input  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
REQ-009 gnt  output  NREQ  combinational one-hot grant; a requester sampling gnt[i]=1 at a rising edge has transferred one word.
REQ-010 cg_en  output  1  registered enable to the latch-based clock gate of the datapath.
REQ-011 dp_din  output  DW  registered data word for the gated datapath register.
REQ-012 dp_valid  output  1  registered, high for one cycle per transferred word.
REQ-013 state  output  2  current FSM state encoding: OFF=0, WAKE=1, ACTIVE=2, IDLE_WAIT=3.
REQ-014 sleep_cnt  output  16  saturating count of transitions into OFF.

Function
REQ-015 The FSM shall have four states: OFF, WAKE, ACTIVE, IDLE_WAIT.
REQ-016 cg_en shall be 0 in OFF and 1 in WAKE, ACTIVE and IDLE_WAIT, registered from the next-state value so it changes on the same edge as state.
REQ-017 OFF: when any req bit is high, the FSM shall go to WAKE and load wake_cnt with WAKE_CYC-1.
REQ-018 WAKE: wake_cnt shall decrement each cycle; at wake_cnt==0 the FSM shall go to ACTIVE; gnt shall be all-zero in WAKE.
REQ-019 ACTIVE, gnt: when any req is high, gnt shall assert exactly one bit, chosen round-robin starting at pointer rr_ptr.
REQ-020 ACTIVE, pointer update: on each grant to requester k, rr_ptr shall become (k+1) mod NREQ.
REQ-021 ACTIVE, data: on each grant to requester k, dp_din shall take din[k*DW +: DW] and dp_valid shall be 1 on the next cycle; latency from grant edge to dp_valid is 1 cycle.
REQ-022 ACTIVE, idle entry: when no req is high, gnt shall be zero, the FSM shall go to IDLE_WAIT and load idle_cnt with IDLE_CYC-1.
REQ-023 IDLE_WAIT: gnt shall be zero; if any req is high the FSM shall go to ACTIVE next cycle with no wake delay.
REQ-024 IDLE_WAIT: otherwise idle_cnt shall decrement, and at idle_cnt==0 the FSM shall go to OFF.
REQ-025 Simultaneous events: a req arriving in the cycle idle_cnt==0 shall win, and the FSM shall go to ACTIVE rather than OFF.
REQ-026 gnt shall be all-zero in every state other than ACTIVE, and shall never have more than one bit set.
REQ-027 dp_valid shall be 0 in every cycle not immediately following a grant; dp_din shall hold its last value when dp_valid is 0.
REQ-028 sleep_cnt shall increment on each IDLE_WAIT->OFF transition and saturate at 16'hFFFF.
REQ-029 A requester dropping req before it is granted shall be tolerated without error; no grant is then issued to it.

Reset
REQ-030 On rst_n low, asynchronously: state=OFF, cg_en=0, gnt=0, dp_din=0, dp_valid=0, rr_ptr=0, wake_cnt=0, idle_cnt=0, sleep_cnt=0.
REQ-031 Reset asserted mid-transfer shall abort the operation with no further dp_valid pulse, and after release the block shall resume from OFF.
REQ-032 The first rising edge of clk_gt after rst_n deasserts shall evaluate the OFF state normally.

Verification
REQ-033 Wake path: after reset, req=4'b0001, din[3:0]=4'hA -> cg_en rises 1 cycle later; gnt=0001 after 2 WAKE cycles; dp_din=4'hA with dp_valid=1 on the next cycle.
REQ-034 Round-robin: req=4'b1111 held in ACTIVE with rr_ptr=0 -> grant order 0,1,2,3,0; exactly one dp_valid per grant.
REQ-035 Gate-off: all req low from ACTIVE -> cg_en stays 1 for 8 IDLE_WAIT cycles, then 0; sleep_cnt increments 0->1.
REQ-036 Race: req=4'b0100 asserted in the cycle idle_cnt==0 -> next state ACTIVE, cg_en never drops, gnt=0100, sleep_cnt unchanged.
REQ-037 Mid-operation reset: rst_n pulsed low during ACTIVE with req=4'b0011 -> all outputs 0 immediately; after release the block re-enters WAKE and the first grant goes to requester 0.
